// File: rtl/multi_dataflow_engine_ctrl_pkg.sv
// Shared types for the multi-dataflow engine sequencer: FSM states and
// engine-level control/flag bundles used at the integration level.
package multi_dataflow_engine_ctrl_pkg;

   localparam int unsigned ENGINE_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN,
      FINISH
   } engine_ctrl_state_t;

   typedef struct packed {
      logic                    start;
      logic [ENGINE_CNT_W-1:0] len;
   } ctrl_engine_t;

   typedef struct packed {
      logic                    busy;
      logic                    done;
      logic [ENGINE_CNT_W-1:0] cnt_out;
      logic                    wdt_err;
   } flags_engine_t;

endpackage

// File: rtl/multi_dataflow_engine_wdt.sv
// Watchdog for the engine sequencer: counts RUN cycles without a kernel done
// beat and flags a sticky error on reaching WDT_CYCLES.
module multi_dataflow_engine_wdt #(
   parameter int unsigned WDT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic run_i,
   input  logic kick_i,
   output logic timeout_o,
   output logic err_o
);

   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   // Outside RUN the counter sits at zero, so every entry into RUN starts fresh.
   assign timeout_o = run_i && !kick_i && (cnt_q == 32'(WDT_CYCLES - 1));

   always_comb begin
      cnt_d = (!run_i || kick_i) ? 32'd0 : cnt_q + 32'd1;
      err_d = err_q | timeout_o;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         cnt_q <= 32'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/multi_dataflow_engine_ctrl.sv
// Initiator-side sequencer for the multi-dataflow kernel adapter.
// Optional watchdog enabled by defining MULTI_DATAFLOW_ENGINE_WDT_EN.
module multi_dataflow_engine_ctrl
   import multi_dataflow_engine_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned WDT_CYCLES = 1024
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             kernel_ready_i,
   input  logic             kernel_done_i,
   input  logic             kernel_idle_i,
   output logic             kernel_start_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] cnt_out_o,
   output logic             wdt_err_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   engine_ctrl_state_t state_q, state_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               zdone_q, zdone_d;
   logic               wdt_timeout;

   // The adapter's ready flag is observed by the integration, not by this FSM.
   logic unused_ready;
   assign unused_ready = kernel_ready_i;

`ifdef MULTI_DATAFLOW_ENGINE_WDT_EN
   multi_dataflow_engine_wdt #(
      .WDT_CYCLES (WDT_CYCLES)
   ) i_wdt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .run_i     (state_q == RUN),
      .kick_i    (kernel_done_i),
      .timeout_o (wdt_timeout),
      .err_o     (wdt_err_o)
   );
`else
   logic [31:0] unused_wdt_cycles;
   assign unused_wdt_cycles = WDT_CYCLES;
   assign wdt_timeout       = 1'b0;
   assign wdt_err_o         = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      zdone_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  len_d   = len_i;
                  cnt_d   = '0;
                  state_d = START;
               end else begin
                  zdone_d = 1'b1;
               end
            end
         end
         START: state_d = RUN;
         RUN: begin
            if (kernel_done_i) cnt_d = cnt_q + ONE;
            // A completing beat wins over both the watchdog and a relaunch.
            if (kernel_done_i && (cnt_q == len_q - ONE)) begin
               state_d = FINISH;
            end else if (wdt_timeout) begin
               state_d = FINISH;
            end else if (kernel_idle_i && (cnt_q < len_q)) begin
               state_d = START;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is synchronous and state uses non-blocking assignments so all
   // registers update together from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         zdone_q <= zdone_d;
      end
   end

   assign kernel_start_o = (state_q == START);
   assign busy_o         = (state_q != IDLE);
   assign done_o         = (state_q == FINISH) || zdone_q;
   assign cnt_out_o      = cnt_q;

endmodule
